// File: rtl/branch_pc_if.sv
// rtl/branch_pc_if.sv - EX-stage redirect bundle between pipeline control and the PC unit
//
// master: pipeline side (drives stall, EX-stage decode/operands, trap_ack)
// slave : branch_pc_unit (drives branch_unsigned, pc, flush, trap_req, counters)
interface branch_pc_if;
    logic        stall;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic        branch_equal;
    logic        branch_lessthan;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] jalr_base;
    logic        trap_ack;
    logic        branch_unsigned;
    logic [31:0] pc;
    logic        flush;
    logic        trap_req;
    logic [15:0] branch_cnt;
    logic [15:0] taken_cnt;

    modport master (
        output stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
               branch_equal, branch_lessthan, ex_pc, ex_imm, jalr_base, trap_ack,
        input  branch_unsigned, pc, flush, trap_req, branch_cnt, taken_cnt
    );

    modport slave (
        input  stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
               branch_equal, branch_lessthan, ex_pc, ex_imm, jalr_base, trap_ack,
        output branch_unsigned, pc, flush, trap_req, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - branch resolution, fetch PC register and misaligned-target trap FSM
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - branch_pc_if.slave: EX-stage inputs, stall, trap_ack in;
//           branch_unsigned (comb), flush (comb), pc, trap_req, branch_cnt, taken_cnt (registered) out
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    branch_pc_if.slave  bus
);

    typedef enum logic {RUN, TRAP} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic        trap_q;
    logic [15:0] branch_cnt_q;
    logic [15:0] taken_cnt_q;

    logic        cond;
    logic        taken;
    logic        misaligned;
    logic        count_branch;
    logic [31:0] target;

    // funct3[2] selects lt vs eq compare, funct3[0] inverts; 010/011 are not branch codes.
    always_comb begin
        cond = 1'b0;
        case (bus.ex_funct3)
            3'b000:  cond =  bus.branch_equal;
            3'b001:  cond = ~bus.branch_equal;
            3'b100:  cond =  bus.branch_lessthan;
            3'b101:  cond = ~bus.branch_lessthan;
            3'b110:  cond =  bus.branch_lessthan;
            3'b111:  cond = ~bus.branch_lessthan;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        target = bus.ex_pc + bus.ex_imm;
        if (bus.ex_is_jalr) begin
            target = (bus.jalr_base + bus.ex_imm) & 32'hFFFF_FFFE;
        end
    end

    assign taken        = bus.ex_valid & ((bus.ex_is_branch & cond) | bus.ex_is_jal | bus.ex_is_jalr);
    assign misaligned   = taken & target[1];
    assign count_branch = bus.ex_valid & bus.ex_is_branch;

    // Redirect is same-cycle so the younger IF/ID slots are squashed in the cycle the
    // decision is made; while trapped everything younger is squashed continuously.
    assign bus.flush = rst_n & ((state == RUN) ? (taken & ~bus.stall) : 1'b1);

    assign bus.branch_unsigned = bus.ex_funct3[1];
    assign bus.pc              = pc_q;
    assign bus.trap_req        = trap_q;
    assign bus.branch_cnt      = branch_cnt_q;
    assign bus.taken_cnt       = taken_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            pc_q         <= RESET_PC;
            trap_q       <= 1'b0;
            branch_cnt_q <= 16'h0000;
            taken_cnt_q  <= 16'h0000;
        end else begin
            case (state)
                RUN: begin
                    if (!bus.stall) begin
                        // Counting is independent of the trap: a misaligned taken branch still counts.
                        if (count_branch) begin
                            branch_cnt_q <= branch_cnt_q + 16'd1;
                            if (cond) begin
                                taken_cnt_q <= taken_cnt_q + 16'd1;
                            end
                        end
                        if (misaligned) begin
                            pc_q   <= TRAP_VEC;
                            trap_q <= 1'b1;
                            state  <= TRAP;
                        end else if (taken) begin
                            pc_q <= target;
                        end else begin
                            pc_q <= pc_q + 32'd4;
                        end
                    end
                end
                TRAP: begin
                    // pc stays parked on the vector; increment resumes from it after return.
                    pc_q <= TRAP_VEC;
                    if (bus.trap_ack) begin
                        state  <= RUN;
                        trap_q <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - scoreboard bench for branch_pc_unit
module tb_branch_pc_unit;

    logic clk;
    logic rst_n;

    branch_pc_if bus ();

    branch_pc_unit #(
        .RESET_PC (32'h0000_0000),
        .TRAP_VEC (32'h0000_0100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          step;
        logic [31:0] pc;
        logic        flush;
        logic        trap;
        logic [15:0] bc;
        logic [15:0] tc;
        logic        bu;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", step, name, act, want);
        end
    endtask

    // Monitor: every cycle the bench has posted an expectation for, compare visible outputs mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc",              e.step, bus.pc,                      e.pc);
                chk("flush",           e.step, {31'd0, bus.flush},          {31'd0, e.flush});
                chk("trap_req",        e.step, {31'd0, bus.trap_req},       {31'd0, e.trap});
                chk("branch_cnt",      e.step, {16'd0, bus.branch_cnt},     {16'd0, e.bc});
                chk("taken_cnt",       e.step, {16'd0, bus.taken_cnt},      {16'd0, e.tc});
                chk("branch_unsigned", e.step, {31'd0, bus.branch_unsigned}, {31'd0, e.bu});
            end
        end
    end

    task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                         input logic [2:0] f3, input logic eq, input logic lt,
                         input logic [31:0] expc, input logic [31:0] imm, input logic [31:0] base,
                         input logic st, input logic ack);
        bus.ex_valid        = v;
        bus.ex_is_branch    = br;
        bus.ex_is_jal       = jal;
        bus.ex_is_jalr      = jalr;
        bus.ex_funct3       = f3;
        bus.branch_equal    = eq;
        bus.branch_lessthan = lt;
        bus.ex_pc           = expc;
        bus.ex_imm          = imm;
        bus.jalr_base       = base;
        bus.stall           = st;
        bus.trap_ack        = ack;
    endtask

    task automatic idle(input logic st, input logic ack);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, st, ack);
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic fl, input logic tr,
                              input logic [15:0] bc, input logic [15:0] tc, input logic bu);
        exp_t e;
        step_no++;
        e.step = step_no; e.pc = pc; e.flush = fl; e.trap = tr; e.bc = bc; e.tc = tc; e.bu = bu;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle(1'b0, 1'b0);
        tick();

        // Reset held with a taken JAL presented: flush must stay low, pc held at RESET_PC.
        drive(1, 0, 1, 0, 3'b000, 0, 0, 32'h40, 32'h8, 32'h0, 0, 0);
        expect_out(32'h0, 0, 0, 16'd0, 16'd0, 0);
        tick();
        rst_n = 1'b1;

        // Idle increment from reset.
        idle(0, 0); expect_out(32'h0, 0, 0, 0, 0, 0); tick();
        idle(0, 0); expect_out(32'h4, 0, 0, 0, 0, 0); tick();
        idle(0, 0); expect_out(32'h8, 0, 0, 0, 0, 0); tick();
        idle(0, 0); expect_out(32'hC, 0, 0, 0, 0, 0); tick();

        // BLTU taken: 0x40 + 0x20.
        drive(1, 1, 0, 0, 3'b110, 0, 1, 32'h40, 32'h20, 32'h0, 0, 0);
        expect_out(32'h10, 1, 0, 0, 0, 1); tick();

        // BNE with equal operands: not taken, counts.
        drive(1, 1, 0, 0, 3'b001, 1, 0, 32'h60, 32'h40, 32'h0, 0, 0);
        expect_out(32'h60, 0, 0, 1, 1, 0); tick();

        // Same BNE under stall: nothing moves.
        drive(1, 1, 0, 0, 3'b001, 1, 0, 32'h60, 32'h40, 32'h0, 1, 0);
        expect_out(32'h64, 0, 0, 2, 1, 0); tick();

        // Taken JAL under stall: no flush, no update.
        drive(1, 0, 1, 0, 3'b000, 0, 0, 32'h60, 32'h40, 32'h0, 1, 0);
        expect_out(32'h64, 0, 0, 2, 1, 0); tick();

        idle(0, 0); expect_out(32'h64, 0, 0, 2, 1, 0); tick();

        // BGE taken with negative offset: 0x80 - 8 = 0x78.
        drive(1, 1, 0, 0, 3'b101, 0, 0, 32'h80, 32'hFFFF_FFF8, 32'h0, 0, 0);
        expect_out(32'h68, 1, 0, 2, 1, 0); tick();

        // BLT not taken.
        drive(1, 1, 0, 0, 3'b100, 0, 0, 32'h80, 32'h40, 32'h0, 0, 0);
        expect_out(32'h78, 0, 0, 3, 2, 0); tick();

        // Reserved funct3 010: cond forced 0 even with both flags set; still counted.
        drive(1, 1, 0, 0, 3'b010, 1, 1, 32'h80, 32'h40, 32'h0, 0, 0);
        expect_out(32'h7C, 0, 0, 4, 2, 1); tick();

        // JAL with ex_valid low: ignored.
        drive(0, 0, 1, 0, 3'b000, 0, 0, 32'h300, 32'h40, 32'h0, 0, 0);
        expect_out(32'h80, 0, 0, 5, 2, 0); tick();

        // JAL target wraps: 0xFFFFFFF0 + 0x14 = 0x4.
        drive(1, 0, 1, 0, 3'b000, 0, 0, 32'hFFFF_FFF0, 32'h14, 32'h0, 0, 0);
        expect_out(32'h84, 1, 0, 5, 2, 0); tick();

        // trap_ack in RUN has no effect.
        idle(0, 1); expect_out(32'h4, 0, 0, 5, 2, 0); tick();

        // JALR 0x101 + 1 = 0x102: misaligned -> trap.
        drive(1, 0, 0, 1, 3'b000, 0, 0, 32'h0, 32'h1, 32'h101, 0, 0);
        expect_out(32'h8, 1, 0, 5, 2, 0); tick();

        // In TRAP, a taken BEQ is ignored; flush held.
        drive(1, 1, 0, 0, 3'b000, 1, 0, 32'h40, 32'h20, 32'h0, 0, 0);
        expect_out(32'h100, 1, 1, 5, 2, 0); tick();

        // trap_ack works under stall.
        idle(1, 1); expect_out(32'h100, 1, 1, 5, 2, 0); tick();
        idle(0, 0); expect_out(32'h100, 0, 0, 5, 2, 0); tick();
        idle(0, 0); expect_out(32'h104, 0, 0, 5, 2, 0); tick();

        // Misaligned taken BEQ (0x0 + 0x6): traps and still counts both.
        drive(1, 1, 0, 0, 3'b000, 1, 0, 32'h0, 32'h6, 32'h0, 0, 0);
        expect_out(32'h108, 1, 0, 5, 2, 0); tick();

        // Reset mid-TRAP with stall: flush low during reset cycle, then RESET_PC.
        rst_n = 1'b0;
        idle(1, 0); expect_out(32'h100, 0, 1, 6, 3, 0); tick();
        rst_n = 1'b1;
        idle(0, 0); expect_out(32'h0, 0, 0, 0, 0, 0); tick();

        // JALR 0x200 + 5 = 0x205 -> bit0 cleared -> 0x204, aligned.
        drive(1, 0, 0, 1, 3'b000, 0, 0, 32'h0, 32'h5, 32'h200, 0, 0);
        expect_out(32'h4, 1, 0, 0, 0, 0); tick();

        // 65535 taken BEQs to 0x210 to preload both counters to 0xFFFF.
        drive(1, 1, 0, 0, 3'b000, 1, 0, 32'h200, 32'h10, 32'h0, 0, 0);
        expect_out(32'h204, 1, 0, 0, 0, 0);
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        expect_out(32'h210, 1, 0, 16'hFFFF, 16'hFFFF, 0); tick();
        idle(0, 0); expect_out(32'h210, 0, 0, 16'h0000, 16'h0000, 0); tick();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
